// File: rtl/apb_pkg.sv
// Shared APB requester types: bus widths, bridge FSM states and command/response records.
package apb_pkg;

   localparam int APB_ADDR_W = 4;
   localparam int APB_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_mstate_t;

   typedef struct packed {
      logic                  write;
      logic [APB_ADDR_W-1:0] addr;
      logic [APB_DATA_W-1:0] wdata;
   } apb_cmd_t;

   typedef struct packed {
      logic [APB_DATA_W-1:0] rdata;
      logic                  err;
      logic                  timeout;
   } apb_rsp_t;

endpackage

// File: rtl/apb_master_bridge_if.sv
// Command/response port plus APB bus of the requester bridge, with bridge-side and environment-side views.
interface apb_master_bridge_if
   import apb_pkg::*;
#(
   parameter int ADDR_W = APB_ADDR_W,
   parameter int DATA_W = APB_DATA_W
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic              rsp_timeout;
   logic [ADDR_W-1:0] paddr;
   logic              psel;
   logic              penable;
   logic              pwrite;
   logic [DATA_W-1:0] pwdata;
   logic [DATA_W-1:0] prdata;
   logic              pready;
   logic              pslverr;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
             paddr, psel, penable, pwrite, pwdata
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
             paddr, psel, penable, pwrite, pwdata
   );

endinterface

// File: rtl/apb_wait_timer.sv
// Saturating wait-state counter; o_expired flags the ACCESS cycle that would make the count hit the limit.
module apb_wait_timer #(
   parameter int unsigned TIMEOUT_CYCLES = 16
)(
   input  logic i_clk,
   input  logic i_srst,
   input  logic i_clear,
   input  logic i_count_en,
   output logic o_expired
);

   generate
      if (TIMEOUT_CYCLES == 0) begin : g_off
         assign o_expired = 1'b0;
      end else begin : g_on
         localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
         localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);
         localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

         logic [CNT_W-1:0] r_cnt;

         always_ff @(posedge i_clk) begin
            if (i_srst || i_clear) begin
               r_cnt <= '0;
            end else if (i_count_en && (r_cnt != LIMIT)) begin
               r_cnt <= r_cnt + 1'b1;
            end
         end

         // A waiting cycle that already has LIMIT-1 behind it is the last one allowed.
         assign o_expired = i_count_en && (r_cnt >= LAST);
      end
   endgenerate

endmodule

// File: rtl/apb_master_bridge.sv
// APB requester: one command at a time, SETUP then ACCESS, one-cycle response pulse, wait-state watchdog.
module apb_master_bridge
   import apb_pkg::*;
#(
   parameter int          ADDR_W         = APB_ADDR_W,
   parameter int          DATA_W         = APB_DATA_W,
   parameter int unsigned TIMEOUT_CYCLES = 16
)(
   input  logic                pclk,
   input  logic                preset,
   apb_master_bridge_if.master bus
);

   apb_mstate_t       r_state;
   logic              r_psel;
   logic              r_penable;
   logic              r_pwrite;
   logic [ADDR_W-1:0] r_paddr;
   logic [DATA_W-1:0] r_pwdata;
   logic              r_rsp_valid;
   logic [DATA_W-1:0] r_rsp_rdata;
   logic              r_rsp_err;
   logic              r_rsp_timeout;

   logic w_accept;
   logic w_wait;
   logic w_expired;

   assign w_accept = (r_state == IDLE) && bus.cmd_valid;
   assign w_wait   = (r_state == ACCESS) && !bus.pready;

   apb_wait_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_wait_timer (
      .i_clk      (pclk),
      .i_srst     (preset),
      .i_clear    (w_accept),
      .i_count_en (w_wait),
      .o_expired  (w_expired)
   );

   always_ff @(posedge pclk) begin
      if (preset) begin
         r_state       <= IDLE;
         r_psel        <= 1'b0;
         r_penable     <= 1'b0;
         r_pwrite      <= 1'b0;
         r_paddr       <= '0;
         r_pwdata      <= '0;
         r_rsp_valid   <= 1'b0;
         r_rsp_rdata   <= '0;
         r_rsp_err     <= 1'b0;
         r_rsp_timeout <= 1'b0;
      end else begin
         r_rsp_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.cmd_valid) begin
                  r_paddr  <= bus.cmd_addr;
                  r_pwrite <= bus.cmd_write;
                  r_pwdata <= bus.cmd_write ? bus.cmd_wdata : '0;
                  r_psel   <= 1'b1;
                  r_state  <= SETUP;
               end
            end
            SETUP: begin
               r_penable <= 1'b1;
               r_state   <= ACCESS;
            end
            ACCESS: begin
               // pready is checked first so a slave answering on the limit cycle still completes.
               if (bus.pready) begin
                  r_psel        <= 1'b0;
                  r_penable     <= 1'b0;
                  r_state       <= IDLE;
                  r_rsp_valid   <= 1'b1;
                  r_rsp_rdata   <= r_pwrite ? '0 : bus.prdata;
                  r_rsp_err     <= bus.pslverr;
                  r_rsp_timeout <= 1'b0;
               end else if (w_expired) begin
                  r_psel        <= 1'b0;
                  r_penable     <= 1'b0;
                  r_state       <= IDLE;
                  r_rsp_valid   <= 1'b1;
                  r_rsp_rdata   <= '0;
                  r_rsp_err     <= 1'b1;
                  r_rsp_timeout <= 1'b1;
               end
            end
            default: begin
               r_psel    <= 1'b0;
               r_penable <= 1'b0;
               r_state   <= IDLE;
            end
         endcase
      end
   end

   assign bus.cmd_ready   = (r_state == IDLE);
   assign bus.paddr       = r_paddr;
   assign bus.psel        = r_psel;
   assign bus.penable     = r_penable;
   assign bus.pwrite      = r_pwrite;
   assign bus.pwdata      = r_pwdata;
   assign bus.rsp_valid   = r_rsp_valid;
   assign bus.rsp_rdata   = r_rsp_rdata;
   assign bus.rsp_err     = r_rsp_err;
   assign bus.rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: vector table of single transfers plus timeout, streaming and reset sequences.
module tb_apb_master_bridge;

   logic pclk;
   logic preset;
   int   errors = 0;
   int   checks = 0;

   apb_master_bridge_if bus ();

   apb_master_bridge #(
      .ADDR_W         (4),
      .DATA_W         (8),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .pclk   (pclk),
      .preset (preset),
      .bus    (bus)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   typedef struct {
      logic       write;
      logic [3:0] addr;
      logic [7:0] wdata;
      logic [7:0] prdata;
      int         waits;
      logic       slverr;
      logic [7:0] exp_rdata;
      logic       exp_err;
   } vec_t;

   typedef struct {
      logic       write;
      logic [3:0] addr;
      logic [7:0] wdata;
      logic [7:0] exp_rdata;
   } b2b_t;

   vec_t vecs [5];
   b2b_t cmds [4];

   task automatic check1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b, want %b", name, act, exp);
      end
   endtask

   task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%02h, want 0x%02h", name, act, exp);
      end
   endtask

   task automatic checki(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   // Single transfer from the vector table; called at a negedge with the bridge idle.
   task automatic run_xfer(input vec_t v, input int id);
      logic [7:0] exp_pwdata;
      exp_pwdata = v.write ? v.wdata : 8'h00;
      check1("idle_cmd_ready", bus.cmd_ready, 1'b1);
      bus.cmd_valid = 1'b1;
      bus.cmd_write = v.write;
      bus.cmd_addr  = v.addr;
      bus.cmd_wdata = v.wdata;
      @(negedge pclk);
      bus.cmd_valid = 1'b0;
      bus.cmd_write = ~v.write;
      bus.cmd_addr  = ~v.addr;
      bus.cmd_wdata = ~v.wdata;
      bus.pready    = 1'b1;
      bus.pslverr   = 1'b1;
      check1("setup_psel", bus.psel, 1'b1);
      check1("setup_penable", bus.penable, 1'b0);
      check1("setup_cmd_ready", bus.cmd_ready, 1'b0);
      check4("setup_paddr", bus.paddr, v.addr);
      check1("setup_pwrite", bus.pwrite, v.write);
      check8("setup_pwdata", bus.pwdata, exp_pwdata);
      for (int w = 0; w <= v.waits; w++) begin
         @(negedge pclk);
         check1("access_psel", bus.psel, 1'b1);
         check1("access_penable", bus.penable, 1'b1);
         check4("access_paddr", bus.paddr, v.addr);
         check1("access_pwrite", bus.pwrite, v.write);
         check8("access_pwdata", bus.pwdata, exp_pwdata);
         check1("access_no_rsp", bus.rsp_valid, 1'b0);
         bus.pready  = (w == v.waits);
         bus.pslverr = (w == v.waits) ? v.slverr : ~v.slverr;
         bus.prdata  = (w == v.waits) ? v.prdata : ~v.prdata;
      end
      @(negedge pclk);
      bus.pready  = 1'b0;
      bus.pslverr = 1'b0;
      check1("rsp_valid", bus.rsp_valid, 1'b1);
      check8("rsp_rdata", bus.rsp_rdata, v.exp_rdata);
      check1("rsp_err", bus.rsp_err, v.exp_err);
      check1("rsp_timeout", bus.rsp_timeout, 1'b0);
      check1("rsp_psel", bus.psel, 1'b0);
      check1("rsp_penable", bus.penable, 1'b0);
      check1("rsp_cmd_ready", bus.cmd_ready, 1'b1);
      $display("xfer %0d: %s addr=0x%0h waits=%0d rdata=0x%02h err=%b", id,
               v.write ? "W" : "R", v.addr, v.waits, bus.rsp_rdata, bus.rsp_err);
      @(negedge pclk);
      check1("rsp_single_pulse", bus.rsp_valid, 1'b0);
   endtask

   // ready_at = 0: slave never answers; otherwise pready rises in that ACCESS cycle (1-based).
   task automatic run_timeout(input int ready_at);
      int         n;
      logic       exp_err;
      logic [7:0] exp_rdata;
      exp_err   = (ready_at == 0);
      exp_rdata = (ready_at == 0) ? 8'h00 : 8'h6B;
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = 4'h9;
      bus.cmd_wdata = 8'h00;
      @(negedge pclk);
      bus.cmd_valid = 1'b0;
      bus.pready    = 1'b0;
      bus.prdata    = 8'h6B;
      check1("to_setup_psel", bus.psel, 1'b1);
      n = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge pclk);
         if (!bus.penable) break;
         n++;
         bus.pready = (n == ready_at);
      end
      bus.pready = 1'b0;
      checki("to_access_cycles", n, 16);
      check1("to_rsp_valid", bus.rsp_valid, 1'b1);
      check1("to_psel", bus.psel, 1'b0);
      check1("to_rsp_err", bus.rsp_err, exp_err);
      check1("to_rsp_timeout", bus.rsp_timeout, exp_err);
      check8("to_rsp_rdata", bus.rsp_rdata, exp_rdata);
      $display("timeout run ready_at=%0d: access=%0d err=%b timeout=%b", ready_at, n,
               bus.rsp_err, bus.rsp_timeout);
      @(negedge pclk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      int idx;
      int rsp_idx;
      int acc_cyc [4];
      logic accepted;

      vecs[0] = '{1'b1, 4'h3, 8'hA5, 8'h00, 0, 1'b0, 8'h00, 1'b0};
      vecs[1] = '{1'b0, 4'hC, 8'h00, 8'h5E, 3, 1'b0, 8'h5E, 1'b0};
      vecs[2] = '{1'b0, 4'h7, 8'h00, 8'h33, 0, 1'b1, 8'h33, 1'b1};
      vecs[3] = '{1'b1, 4'hF, 8'h3C, 8'h99, 2, 1'b1, 8'h00, 1'b1};
      vecs[4] = '{1'b0, 4'h0, 8'h00, 8'hFF, 1, 1'b0, 8'hFF, 1'b0};

      cmds[0] = '{1'b1, 4'h1, 8'h11, 8'h00};
      cmds[1] = '{1'b0, 4'h2, 8'h00, 8'hD2};
      cmds[2] = '{1'b1, 4'hF, 8'hFF, 8'h00};
      cmds[3] = '{1'b0, 4'h0, 8'h00, 8'hF0};

      preset        = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = 4'h0;
      bus.cmd_wdata = 8'h00;
      bus.prdata    = 8'h00;
      bus.pready    = 1'b0;
      bus.pslverr   = 1'b0;
      repeat (3) @(negedge pclk);
      check1("rst_psel", bus.psel, 1'b0);
      check1("rst_penable", bus.penable, 1'b0);
      check1("rst_pwrite", bus.pwrite, 1'b0);
      check4("rst_paddr", bus.paddr, 4'h0);
      check8("rst_pwdata", bus.pwdata, 8'h00);
      check1("rst_rsp_valid", bus.rsp_valid, 1'b0);
      check1("rst_rsp_err", bus.rsp_err, 1'b0);
      check1("rst_rsp_timeout", bus.rsp_timeout, 1'b0);
      check8("rst_rsp_rdata", bus.rsp_rdata, 8'h00);
      preset = 1'b0;
      @(negedge pclk);
      check1("post_rst_cmd_ready", bus.cmd_ready, 1'b1);

      for (int i = 0; i < 5; i++) run_xfer(vecs[i], i);

      run_timeout(0);
      run_timeout(16);

      // Streaming: cmd_valid held high, slave always ready, prdata = {~paddr, paddr}.
      idx     = 0;
      rsp_idx = 0;
      bus.pready    = 1'b1;
      bus.cmd_valid = 1'b1;
      bus.cmd_write = cmds[0].write;
      bus.cmd_addr  = cmds[0].addr;
      bus.cmd_wdata = cmds[0].wdata;
      for (int cyc = 0; cyc < 30; cyc++) begin
         accepted = bus.cmd_ready && bus.cmd_valid;
         @(negedge pclk);
         if (accepted && idx < 4) begin
            acc_cyc[idx] = cyc;
            idx++;
            if (idx < 4) begin
               bus.cmd_write = cmds[idx].write;
               bus.cmd_addr  = cmds[idx].addr;
               bus.cmd_wdata = cmds[idx].wdata;
            end else begin
               bus.cmd_valid = 1'b0;
            end
         end
         bus.prdata = {~bus.paddr, bus.paddr};
         if (bus.penable && rsp_idx < 4) begin
            check4("b2b_paddr", bus.paddr, cmds[rsp_idx].addr);
            check1("b2b_pwrite", bus.pwrite, cmds[rsp_idx].write);
            check8("b2b_pwdata", bus.pwdata, cmds[rsp_idx].write ? cmds[rsp_idx].wdata : 8'h00);
         end
         if (bus.rsp_valid && rsp_idx < 4) begin
            check8("b2b_rsp_rdata", bus.rsp_rdata, cmds[rsp_idx].exp_rdata);
            check1("b2b_rsp_err", bus.rsp_err, 1'b0);
            check1("b2b_gap_psel", bus.psel, 1'b0);
            $display("b2b %0d: addr=0x%0h rdata=0x%02h", rsp_idx, cmds[rsp_idx].addr, bus.rsp_rdata);
            rsp_idx++;
         end
      end
      bus.pready = 1'b0;
      checki("b2b_accepted", idx, 4);
      checki("b2b_responses", rsp_idx, 4);
      for (int i = 1; i < 4; i++) begin
         if (i < idx) checki("b2b_spacing", acc_cyc[i] - acc_cyc[i-1], 3);
      end

      // Reset pulse in ACCESS of a read: no response, back to idle, next transfer normal.
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = 4'h5;
      @(negedge pclk);
      bus.cmd_valid = 1'b0;
      bus.pready    = 1'b0;
      @(negedge pclk);
      check1("prerst_penable", bus.penable, 1'b1);
      preset = 1'b1;
      @(negedge pclk);
      check1("midrst_psel", bus.psel, 1'b0);
      check1("midrst_penable", bus.penable, 1'b0);
      check1("midrst_rsp_valid", bus.rsp_valid, 1'b0);
      check1("midrst_cmd_ready", bus.cmd_ready, 1'b1);
      check4("midrst_paddr", bus.paddr, 4'h0);
      preset = 1'b0;
      @(negedge pclk);
      check1("postrst_rsp_valid", bus.rsp_valid, 1'b0);
      check1("postrst_psel", bus.psel, 1'b0);
      $display("reset pulse during ACCESS applied");
      run_xfer(vecs[1], 5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
